// File: rtl/aes_model_pack.sv
// Shared AES key-schedule types and tables.
// S-box, round constants, key width and FSM state.
package aes_model_pack;

  localparam int DATA_WIDTH_IN_BYTES = 16;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam logic [7:0] SUB_BYTES_TABLE [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // Index 0 and 11..15 are never used by a 10-round schedule.
  localparam logic [7:0] RCON [16] = '{
    8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,
    8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00
  };

endpackage

// File: rtl/aes_g_word.sv
// Key-schedule g function: RotWord, SubWord, RCON.
// Purely combinational.
module aes_g_word
  import aes_model_pack::*;
(
  input  logic [31:0] i_word,
  input  logic [3:0]  i_round,
  output logic [31:0] o_word
);

  logic [31:0] w_rot;
  logic [31:0] w_sub;

  assign w_rot = {i_word[7:0], i_word[31:8]};

  assign w_sub = {
    SUB_BYTES_TABLE[w_rot[31:24]],
    SUB_BYTES_TABLE[w_rot[23:16]],
    SUB_BYTES_TABLE[w_rot[15:8]],
    SUB_BYTES_TABLE[w_rot[7:0]]
  };

  assign o_word = w_sub ^ {24'h0, RCON[i_round]};

endmodule

// File: rtl/aes_key_scheduler.sv
// AES-128 key scheduler: emits one round key per
// accepted handshake, round 0 through NUM_ROUNDS.
module aes_key_scheduler #(
  parameter int DATA_WIDTH_IN_BYTES =
    aes_model_pack::DATA_WIDTH_IN_BYTES,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH_IN_BYTES*8-1:0] key_in,
  input  logic                           key_valid,
  output logic                           key_ready,
  input  logic                           flush,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0] round_key,
  output logic [3:0]                     round_idx,
  output logic                           round_key_valid,
  input  logic                           round_key_ready,
  output logic                           busy
);

  localparam int KW = DATA_WIDTH_IN_BYTES * 8;

  aes_model_pack::state_t r_state;
  logic [KW-1:0] r_key;
  logic [3:0]    r_idx;
  logic          r_valid;
  logic          r_ready;
  logic          r_busy;

  logic [3:0]    w_rnd;
  logic [31:0]   w_t;
  logic [31:0]   w_n0;
  logic [31:0]   w_n1;
  logic [31:0]   w_n2;
  logic [31:0]   w_n3;
  logic [KW-1:0] w_next;

  assign w_rnd = r_idx + 4'd1;

  aes_g_word u_g (
    .i_word  (r_key[127:96]),
    .i_round (w_rnd),
    .o_word  (w_t)
  );

  assign w_n0   = r_key[31:0]   ^ w_t;
  assign w_n1   = r_key[63:32]  ^ w_n0;
  assign w_n2   = r_key[95:64]  ^ w_n1;
  assign w_n3   = r_key[127:96] ^ w_n2;
  assign w_next = {w_n3, w_n2, w_n1, w_n0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= aes_model_pack::IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else if (flush) begin
      r_state <= aes_model_pack::IDLE;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        aes_model_pack::IDLE: begin
          if (key_valid && r_ready) begin
            r_state <= aes_model_pack::EMIT;
            r_key   <= key_in;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        aes_model_pack::EMIT: begin
          if (r_valid && round_key_ready) begin
            if (r_idx == 4'(NUM_ROUNDS)) begin
              r_state <= aes_model_pack::IDLE;
              r_valid <= 1'b0;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_key <= w_next;
              r_idx <= w_rnd;
            end
          end
        end
        default: r_state <= aes_model_pack::IDLE;
      endcase
    end
  end

  assign round_key       = r_key;
  assign round_idx       = r_idx;
  assign round_key_valid = r_valid;
  assign key_ready       = r_ready;
  assign busy            = r_busy;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Scoreboard bench for aes_key_scheduler with an
// independent GF(2^8) key-expansion model.
module tb_aes_key_scheduler;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         flush;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         round_key_valid;
  logic         round_key_ready;
  logic         busy;

  aes_key_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_in          (key_in),
    .key_valid       (key_valid),
    .key_ready       (key_ready),
    .flush           (flush),
    .round_key       (round_key),
    .round_idx       (round_idx),
    .round_key_valid (round_key_valid),
    .round_key_ready (round_key_ready),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int key_cyc = 0;
  int kc[$];
  int acc_cyc [11];
  logic [127:0] seen [11];
  logic [131:0] sb[$];
  logic [7:0]   m_sbox [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [135:0] got,
                       input logic [135:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b,
                                      input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
         ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  // Convert FIPS byte listing (byte 0 first) to port order
  function automatic logic [127:0] bs(input logic [127:0] be);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = be[127-8*k -: 8];
    return r;
  endfunction

  function automatic logic [127:0] m_expand(input logic [127:0] k,
                                            input int r);
    logic [7:0] b [16];
    logic [7:0] t [4];
    logic [7:0] rc;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = k[8*i +: 8];
    rc = 8'h01;
    for (int i = 1; i < r; i++)
      rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
    for (int j = 0; j < 4; j++) t[j] = m_sbox[b[12 + ((j + 1) % 4)]];
    t[0] = t[0] ^ rc;
    for (int j = 0; j < 4; j++) b[j] = b[j] ^ t[j];
    for (int i = 4; i < 16; i++) b[i] = b[i] ^ b[i-4];
    for (int i = 0; i < 16; i++) o[8*i +: 8] = b[i];
    return o;
  endfunction

  function automatic void push_sched(input logic [127:0] k);
    logic [127:0] c;
    c = k;
    sb.push_back({4'd0, c});
    for (int r = 1; r <= 10; r++) begin
      c = m_expand(c, r);
      sb.push_back({4'(r), c});
    end
  endfunction

  // Monitor: inputs are driven 1 time unit after posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid && key_ready && !flush) begin
        push_sched(key_in);
        n_acc++;
        key_cyc = cyc;
        kc.push_back(cyc);
      end
      if (round_key_valid && round_key_ready && !flush) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 136'(sb.size()), 136'd1);
        end else begin
          check("rk", {round_idx, round_key}, sb.pop_front());
          if (round_idx <= 4'd10) begin
            seen[round_idx]    = round_key;
            acc_cyc[round_idx] = cyc;
          end
        end
      end
    end
  end

  task automatic start_key(input logic [127:0] k);
    @(posedge clk); #1;
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_idx(input logic [3:0] idx, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (round_key_valid && round_idx == idx) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("wait_idx", 136'(round_idx), 136'(idx));
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!round_key_valid && key_ready && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_tmo", {round_key_valid, key_ready}, 2'b01);
  endtask

  logic [127:0] k_fips;
  logic [127:0] k_zero;
  logic [127:0] hold_k;

  initial begin
    for (int i = 0; i < 256; i++) m_sbox[i] = calc_sbox(8'(i));
    k_fips = bs(128'h2b7e151628aed2a6abf7158809cf4f3c);
    k_zero = '0;
    rst_n = 1'b0;
    key_in = '0;
    key_valid = 1'b0;
    flush = 1'b0;
    round_key_ready = 1'b1;

    @(posedge clk); #1;
    check("rst_kready", key_ready, 1'b1);
    check("rst_valid", round_key_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_key", round_key, 128'h0);
    check("rst_idx", round_idx, 4'h0);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_valid", round_key_valid, 1'b0);

    // FIPS-197 key, continuous ready
    start_key(k_fips);
    check("lat_idx0", {round_key_valid, round_idx}, 5'h10);
    wait_done(40);
    check("fips_kat1", seen[1], bs(128'ha0fafe1788542cb123a339392a6c7605));
    check("fips_kat10", seen[10], bs(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    check("lat_cyc", 136'(acc_cyc[0] - key_cyc), 136'd1);
    check("span_cyc", 136'(acc_cyc[10] - acc_cyc[0]), 136'd10);

    // Back-pressure at idx4
    start_key(k_fips);
    wait_idx(4'd4, 20);
    round_key_ready = 1'b0;
    hold_k = round_key;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_idx", round_idx, 4'd4);
      check("stall_key", round_key, hold_k);
      check("stall_valid", round_key_valid, 1'b1);
    end
    round_key_ready = 1'b1;
    wait_done(40);
    check("stall_kat10", seen[10], bs(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    // Flush while idx6 is handshaking, then zero key
    start_key(k_fips);
    wait_idx(4'd6, 20);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", round_key_valid, 1'b0);
    check("flush_kready", key_ready, 1'b1);
    check("flush_busy", busy, 1'b0);
    sb.delete();
    start_key(k_zero);
    check("restart_idx0", {round_key_valid, round_idx}, 5'h10);
    wait_done(40);
    check("zero_kat1", seen[1], bs(128'h62636363626363636263636362636363));
    check("zero_kat10", seen[10], bs(128'hb4ef5bcb3e92e21123e951cf6f8f188e));

    // Asynchronous reset mid-schedule
    start_key(k_fips);
    wait_idx(4'd3, 20);
    #3 rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_valid", round_key_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_kready", key_ready, 1'b1);
    check("arst_key", round_key, 128'h0);
    check("arst_idx", round_idx, 4'h0);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_valid", round_key_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    // key_valid held high through EMIT
    n_acc = 0;
    kc.delete();
    @(posedge clk); #1;
    key_in = k_fips;
    key_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (busy) begin
        key_in = k_zero;
        check("kr_emit", key_ready, 1'b0);
      end
      if (n_acc == 2) break;
    end
    key_valid = 1'b0;
    wait_done(40);
    check("hold_nacc", 136'(n_acc), 136'd2);
    if (kc.size() >= 2)
      check("hold_gap", 136'(kc[1] - kc[0]), 136'd12);
    else
      check("hold_kc", 136'(kc.size()), 136'd2);
    check("hold_kat10", seen[10], bs(128'hb4ef5bcb3e92e21123e951cf6f8f188e));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
